// File: rtl/vector_reduce_unit.sv
// Sequential vector reduction: snapshots a vector on start, folds one element per clock
// (sum / signed max / signed min / OR) and offers the scalar on a valid/ready handshake.
//
// state  | meaning
// S_IDLE | waiting for start; outputs idle
// S_RUN  | folding r_buf[r_idx] into r_acc, one element per cycle
// S_DONE | result presented; held until result_ready handshake
module vector_reduce_unit #(
    parameter int BITS = 8,
    parameter int N    = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] V [N],
    input  logic [BITS-1:0] V_len,
    input  logic [1:0]      op,
    input  logic            start,
    output logic            busy,
    output logic [BITS-1:0] result,
    output logic            result_valid,
    input  logic            result_ready
);

    localparam int IW = $clog2(N + 1);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [BITS-1:0] r_buf [N];
    logic [1:0]      r_op;
    logic [BITS-1:0] r_len;
    logic [IW-1:0]   r_idx;
    logic [BITS-1:0] r_acc;
    logic [BITS-1:0] r_result;
    logic            r_valid;
    logic            r_busy;

    logic [BITS-1:0] w_eff_len;
    logic [AW-1:0]   w_idx;
    logic [BITS-1:0] w_e;
    logic [BITS-1:0] w_acc_next;
    logic            w_last;
    logic            w_accept;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_eff_len = (32'(V_len) > N) ? BITS'(N) : V_len;
    assign w_idx     = r_idx[AW-1:0];
    assign w_e       = r_buf[w_idx];
    assign w_last    = (32'(r_idx) == (32'(r_len) - 32'd1));

    // First element seeds the accumulator so max/min are not biased by the cleared acc.
    always_comb begin
        w_acc_next = r_acc;
        if (r_idx == '0) begin
            w_acc_next = w_e;
        end else begin
            case (r_op)
                2'b00:   w_acc_next = r_acc + w_e;
                2'b01:   if ($signed(w_e) > $signed(r_acc)) w_acc_next = w_e;
                2'b10:   if ($signed(w_e) < $signed(r_acc)) w_acc_next = w_e;
                default: w_acc_next = r_acc | w_e;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_buf <= V;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (start) begin
                        r_op    <= op;
                        r_len   <= w_eff_len;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (w_eff_len == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    if (w_last) r_state <= S_DONE;
                    else        r_idx   <= r_idx + IW'(1);
                end
                S_DONE: begin
                    // Result and valid register one cycle after entering DONE.
                    r_result <= r_acc;
                    if (r_valid && result_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_valid;

endmodule

// File: tb/tb_vector_reduce_unit.sv
// Directed bench for vector_reduce_unit (BITS=8, N=4) with hand-computed expectations.
module tb_vector_reduce_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] V [4];
    logic [7:0] V_len;
    logic [1:0] op;
    logic       start;
    logic       busy;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready;

    int n_chk = 0;
    int n_bad = 0;

    vector_reduce_unit #(.BITS(8), .N(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .V            (V),
        .V_len        (V_len),
        .op           (op),
        .start        (start),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_v(input logic [7:0] a, b, c, d);
        V[0] = a; V[1] = b; V[2] = c; V[3] = d;
    endtask

    // Launch one reduction with ready held high; lat = edges from the start edge to valid.
    task automatic reduce(input logic [7:0] a, b, c, d, input logic [7:0] len,
                          input logic [1:0] o, input logic [7:0] exp, input int lat,
                          input string tag);
        int k;
        @(negedge clk);
        set_v(a, b, c, d);
        V_len = len; op = o; start = 1'b1; result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        k = 0;
        while (!result_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_res"}, 32'(result), 32'(exp));
        @(negedge clk);
        chk({tag, "_vld_drop"}, 32'(result_valid), 32'd0);
        chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n_vld;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; V_len = 8'd0; result_ready = 1'b0;
        set_v(8'h00, 8'h00, 8'h00, 8'h00);
        #23;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld", 32'(result_valid), 32'd0);
        chk("rst_res", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        reduce(8'h10, 8'h20, 8'h30, 8'hF0, 8'd4, 2'b00, 8'h50, 5, "sum_wrap");
        reduce(8'h05, 8'h80, 8'h7F, 8'hFF, 8'd4, 2'b01, 8'h7F, 5, "smax");
        reduce(8'h05, 8'h80, 8'h7F, 8'hFF, 8'd4, 2'b10, 8'h80, 5, "smin");
        reduce(8'h01, 8'h02, 8'h04, 8'h08, 8'd9, 2'b11, 8'h0F, 5, "clamp_or");
        reduce(8'h11, 8'h22, 8'h33, 8'h44, 8'd0, 2'b00, 8'h00, 1, "zero_len");
        reduce(8'hFF, 8'h81, 8'h00, 8'h00, 8'd2, 2'b10, 8'h81, 3, "min_len2");

        // Snapshot: inputs change and start pulses while running.
        @(negedge clk);
        set_v(8'h01, 8'h02, 8'h03, 8'h04);
        V_len = 8'd4; op = 2'b00; start = 1'b1; result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        set_v(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        op = 2'b11; V_len = 8'd1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 2;
        while (!result_valid && k < 20) begin
            chk("snap_busy", 32'(busy), 32'd1);
            @(negedge clk);
            k++;
        end
        chk("snap_lat", k, 5);
        chk("snap_res", 32'(result), 32'h0A);
        n_vld = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (result_valid) n_vld++;
        end
        chk("snap_one_result", n_vld, 0);

        // Back-pressure, then start on the handshake cycle (ignored) and one later (accepted).
        @(negedge clk);
        set_v(8'h01, 8'h02, 8'h04, 8'h08);
        V_len = 8'd4; op = 2'b11; start = 1'b1; result_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!result_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("bp_lat", k, 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_vld_hold", 32'(result_valid), 32'd1);
            chk("bp_res_hold", 32'(result), 32'h0F);
        end
        result_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("hs_vld_drop", 32'(result_valid), 32'd0);
        chk("hs_start_ignored", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        k = 0;
        while (!result_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("restart_lat", k, 5);
        chk("restart_res", 32'(result), 32'h0F);
        @(negedge clk);

        // Reset while RUN is at idx=2; previous result (0x0F) must be cleared.
        @(negedge clk);
        set_v(8'h05, 8'h06, 8'h07, 8'h08);
        V_len = 8'd4; op = 2'b00; start = 1'b1; result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_res", 32'(result), 32'h0F);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_vld", 32'(result_valid), 32'd0);
        chk("arst_res", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_vld = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (result_valid || busy) n_vld++;
        end
        chk("post_rst_idle", n_vld, 0);
        reduce(8'h01, 8'h01, 8'h01, 8'h01, 8'd4, 2'b00, 8'h04, 5, "post_rst_sum");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
